// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the MSB-first serial-in parallel-out receiver.
package sipo_pkg;

    localparam int unsigned WIDTH_DEF = 4;

    // Bits needed to hold a count in the range 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Even-parity bit of a zero-extended word.
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Bit-position counter for word assembly; wraps to 0 after LIMIT-1.
module sipo_bit_counter #(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic             load1,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    assign last = (cnt == CNT_W'(LIMIT - 1));

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= CNT_W'(1);
        end else if (inc) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sipo_lshift_rx.sv
// MSB-first SIPO receiver: assembles WIDTH-bit words and strobes valid for one cycle.
// Optional SIPO_PARITY_CHECK_EN adds a trailing even-parity bit per frame and drives perr.
module sipo_lshift_rx
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in,
    input  logic             shift,
    input  logic             sync,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             busy,
    output logic             perr
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
`ifdef SIPO_PARITY_CHECK_EN
    localparam int unsigned LIMIT = WIDTH + 1;
`else
    localparam int unsigned LIMIT = WIDTH;
`endif

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word_c;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             sample;
    logic             data_done;

    assign sample    = shift & ~sync;
    assign word_c    = {sr[WIDTH-2:0], in};
    assign data_done = sample & (cnt == CNT_W'(WIDTH - 1));

    sipo_bit_counter #(
        .LIMIT (LIMIT),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (sample),
        .clr   (sync & ~shift),
        .load1 (sync & shift),
        .cnt   (cnt),
        .last  (last)
    );

    // sync with shift high starts a fresh word with the current bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            sr <= '0;
        end else if (sync) begin
            sr <= WIDTH'(shift & in);
        end else if (shift) begin
            sr <= word_c;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out <= '0;
        end else if (data_done) begin
            out <= word_c;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
        end else begin
            valid <= sample & last;
        end
    end

    // Tracks cnt != 0 after the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= 1'b0;
        end else if (sync) begin
            busy <= shift;
        end else if (shift) begin
            busy <= ~last;
        end
    end

`ifdef SIPO_PARITY_CHECK_EN
    // Data word is already in out when the parity bit arrives.
    always_ff @(posedge clock) begin
        if (reset || sync) begin
            perr <= 1'b0;
        end else if (sample && last) begin
            perr <= even_parity(64'(out)) ^ in;
        end
    end
`else
    assign perr = 1'b0;
`endif

endmodule
